// File: rtl/ask_keyer.sv
// On-off-keying ASK stage: gates the NCO carrier by a serial bit, each bit held for SPS samples.
// Latency: 1 clken cycle carrier_i -> ask_o. Optional ASK_RAMP_EN adds a linear amplitude ramp.
// Backpressure: one-deep bit holding register, bit_ready_o = !full; an empty register at a symbol end pulses underrun_o.
module ask_keyer #(
  parameter int DW      = 14,
  parameter int SPS     = 8,
  parameter int CNT_W   = 16,
  parameter int RAMP_SH = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clken,
  input  logic [DW-1:0] carrier_i,
  input  logic          carrier_valid_i,
  input  logic          bit_i,
  input  logic          bit_valid_i,
  output logic          bit_ready_o,
  output logic [DW-1:0] ask_o,
  output logic          ask_valid_o,
  output logic          sym_strobe_o,
  output logic          busy_o,
  output logic          underrun_o
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);

  state_t           state;
  state_t           nxt_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic             full;
  logic             held_bit;
  logic             cur_bit;
  logic             nxt_cur;
  logic             out_bit;
  logic             consume;
  logic             strb;
  logic             udr;
  logic             ev;
  logic             accept;

  assign ev          = clken & carrier_valid_i;
  assign accept      = clken & bit_valid_i & ~full;
  assign bit_ready_o = ~full;

  // Next-state decode for a sample event; only applied when ev is high.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_cur   = cur_bit;
    out_bit   = cur_bit;
    consume   = 1'b0;
    strb      = 1'b0;
    udr       = 1'b0;
    case (state)
      IDLE: begin
        out_bit = 1'b0;
        if (full) begin
          consume   = 1'b1;
          nxt_state = ACTIVE;
          nxt_cur   = held_bit;
          out_bit   = held_bit;
          strb      = 1'b1;
          // Sample 0 of the symbol is emitted by this event, so the next one is sample 1.
          nxt_cnt   = CNT_W'(1);
        end
      end
      ACTIVE: begin
        strb = (cnt == '0);
        if (cnt != LAST) begin
          nxt_cnt = cnt + CNT_W'(1);
        end else begin
          nxt_cnt = '0;
          if (full) begin
            consume = 1'b1;
            nxt_cur = held_bit;
          end else begin
            udr       = 1'b1;
            nxt_state = IDLE;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

`ifdef ASK_RAMP_EN
  localparam int AMP_MAX = 1 << RAMP_SH;
  logic [RAMP_SH:0]             amp;
  logic [RAMP_SH:0]             amp_tgt;
  logic signed [DW+RAMP_SH+1:0] prod;
  assign amp_tgt = (nxt_state == ACTIVE && nxt_cur) ? (RAMP_SH+1)'(AMP_MAX) : '0;
  assign prod    = $signed(carrier_i) * $signed({1'b0, amp});
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      full         <= 1'b0;
      held_bit     <= 1'b0;
      cur_bit      <= 1'b0;
      ask_o        <= '0;
      ask_valid_o  <= 1'b0;
      sym_strobe_o <= 1'b0;
      busy_o       <= 1'b0;
      underrun_o   <= 1'b0;
`ifdef ASK_RAMP_EN
      amp          <= '0;
`endif
    end else if (clken) begin
      ask_valid_o  <= carrier_valid_i;
      sym_strobe_o <= 1'b0;
      underrun_o   <= 1'b0;
      full         <= accept | (full & ~(ev & consume));
      if (accept) held_bit <= bit_i;
      if (ev) begin
        state        <= nxt_state;
        cnt          <= nxt_cnt;
        cur_bit      <= nxt_cur;
        sym_strobe_o <= strb;
        underrun_o   <= udr;
        busy_o       <= (nxt_state == ACTIVE);
`ifdef ASK_RAMP_EN
        // Output uses the amplitude before this event's step.
        ask_o <= DW'(prod >>> RAMP_SH);
        if (amp < amp_tgt)      amp <= amp + 1'b1;
        else if (amp > amp_tgt) amp <= amp - 1'b1;
`else
        ask_o <= out_bit ? carrier_i : '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ask_keyer.sv
// Scoreboard bench for ask_keyer (default build): directed stimulus pushes expected samples, a monitor pops and compares.
module tb_ask_keyer;

  logic        clk;
  logic        reset_n;
  logic        clken;
  logic [13:0] carrier_i;
  logic        carrier_valid_i;
  logic        bit_i;
  logic        bit_valid_i;
  logic        bit_ready_o;
  logic [13:0] ask_o;
  logic        ask_valid_o;
  logic        sym_strobe_o;
  logic        busy_o;
  logic        underrun_o;

  ask_keyer #(.DW(14), .SPS(8), .CNT_W(16), .RAMP_SH(2)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .clken           (clken),
    .carrier_i       (carrier_i),
    .carrier_valid_i (carrier_valid_i),
    .bit_i           (bit_i),
    .bit_valid_i     (bit_valid_i),
    .bit_ready_o     (bit_ready_o),
    .ask_o           (ask_o),
    .ask_valid_o     (ask_valid_o),
    .sym_strobe_o    (sym_strobe_o),
    .busy_o          (busy_o),
    .underrun_o      (underrun_o)
  );

  typedef struct packed {
    logic [13:0] ask;
    logic        strb;
    logic        udr;
    logic        busy;
  } exp_t;

  exp_t        expq[$];
  logic        bq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_smp    = 0;
  logic        clken_q  = 1'b0;
  logic        in_reset = 1'b1;
  logic signed [13:0] tab [4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) clken_q <= clken;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every output sample produced by a clken cycle is matched against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && clken_q && ask_valid_o) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL sample %0d: unexpected output ask=%0d", n_smp, $signed(ask_o));
        end else begin
          e = expq.pop_front();
          if (ask_o !== e.ask || sym_strobe_o !== e.strb || underrun_o !== e.udr || busy_o !== e.busy) begin
            n_fail++;
            $display("FAIL sample %0d: got ask=%0d strb=%0b udr=%0b busy=%0b, expected ask=%0d strb=%0b udr=%0b busy=%0b",
                     n_smp, $signed(ask_o), sym_strobe_o, underrun_o, busy_o,
                     $signed(e.ask), e.strb, e.udr, e.busy);
          end
        end
        n_smp++;
      end
    end
  end

  task automatic present();
    bit_valid_i = (bq.size() != 0);
    bit_i       = (bq.size() != 0) ? bq[0] : 1'b0;
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic tick(input logic ce, input logic cv, input logic signed [13:0] car,
                      input logic on, input logic strb, input logic udr, input logic busy);
    exp_t e;
    logic hs;
    clken           = ce;
    carrier_valid_i = cv;
    carrier_i       = car;
    if (ce && cv && !in_reset) begin
      e.ask  = on ? car : 14'sd0;
      e.strb = strb;
      e.udr  = udr;
      e.busy = busy;
      expq.push_back(e);
    end
    #4;
    hs = bit_valid_i & bit_ready_o & clken;
    @(negedge clk);
    if (hs) void'(bq.pop_front());
    present();
  endtask

  task automatic load_bits();
    present();
    tick(1'b1, 1'b0, 14'sd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic pat [3];
    logic signed [13:0] ext;
    tab[0] = 14'sd0; tab[1] = 14'sd8191; tab[2] = 14'sd0; tab[3] = -14'sd8191;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
    reset_n = 1'b0; clken = 1'b0; carrier_i = '0; carrier_valid_i = 1'b0;
    bit_i = 1'b0; bit_valid_i = 1'b0;
    @(negedge clk);

    // Reset held with carrier running.
    for (int k = 0; k < 7; k++) tick(1'b1, 1'b1, tab[k % 4], 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_ask",   ask_o,        0);
    chk("rst_valid", ask_valid_o,  0);
    chk("rst_ready", bit_ready_o,  1);
    chk("rst_busy",  busy_o,       0);
    chk("rst_strb",  sym_strobe_o, 0);
    chk("rst_udr",   underrun_o,   0);
    reset_n  = 1'b1;
    in_reset = 1'b0;
    tick(1'b1, 1'b1, 14'sd8191, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_valid", ask_valid_o, 1);

    // Single bit 1: eight carrier samples, underrun with the last.
    bq.push_back(1'b1);
    load_bits();
    chk("single_ready_full", bit_ready_o, 0);
    for (int k = 0; k < 8; k++) tick(1'b1, 1'b1, tab[k % 4], 1'b1, k == 0, k == 7, k != 7);
    chk("single_busy_end", busy_o, 0);
    tick(1'b1, 1'b1, 14'sd8191, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back 1,0,1.
    bq.push_back(1'b1); bq.push_back(1'b0); bq.push_back(1'b1);
    load_bits();
    for (int k = 0; k < 24; k++)
      tick(1'b1, 1'b1, tab[k % 4], pat[k / 8], (k % 8) == 0, k == 23, k != 23);
    tick(1'b1, 1'b1, 14'sd8191, 1'b0, 1'b0, 1'b0, 1'b0);

    // Backpressure with clken toggling 1:1.
    bq.push_back(1'b1); bq.push_back(1'b1);
    load_bits();
    chk("bp_ready_loaded", bit_ready_o, 0);
    for (int k = 0; k < 16; k++) begin
      tick(1'b1, 1'b1, tab[k % 4], 1'b1, (k % 8) == 0, k == 15, k != 15);
      if (k == 1) chk("bp_ready_refilled", bit_ready_o, 0);
      if (k == 6) chk("bp_ready_held",     bit_ready_o, 0);
      if (k == 7) chk("bp_ready_consumed", bit_ready_o, 1);
      tick(1'b0, 1'b1, 14'sd1234, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 0) chk("bp_ready_no_clken", bit_ready_o, 1);
    end
    chk("bp_busy_end", busy_o, 0);

    // Full-scale extremes pass unchanged.
    bq.push_back(1'b1);
    load_bits();
    for (int k = 0; k < 8; k++) begin
      ext = (k % 2) ? 14'sd8191 : -14'sd8192;
      tick(1'b1, 1'b1, ext, 1'b1, k == 0, k == 7, k != 7);
    end

    // Reset at sample 4 with a second bit held.
    bq.push_back(1'b1); bq.push_back(1'b1);
    load_bits();
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b1, 14'sd5000, 1'b1, k == 0, 1'b0, 1'b1);
    chk("mid_ready_full", bit_ready_o, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ask",   ask_o,       0);
    chk("mid_rst_valid", ask_valid_o, 0);
    chk("mid_rst_busy",  busy_o,      0);
    chk("mid_rst_ready", bit_ready_o, 1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b1, 14'sd5000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 14'sd0, 1'b0, 1'b0, 1'b0, 1'b0);

    chk("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
